// File: rtl/vending_fsm_multi_pkg.sv
// Shared encodings for the multi-slot vending controller: FSM states, coin codes
// and the face value of each coin.
package vending_fsm_multi_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NONE = 2'd0;
  localparam coin_code_t COIN_ONE  = 2'd1;
  localparam coin_code_t COIN_FIVE = 2'd2;
  localparam coin_code_t COIN_TEN  = 2'd3;

  localparam logic [3:0] VAL_ONE  = 4'd1;
  localparam logic [3:0] VAL_FIVE = 4'd5;
  localparam logic [3:0] VAL_TEN  = 4'd10;

  function automatic logic [3:0] coin_value(input coin_code_t code);
    logic [3:0] val;
    case (code)
      COIN_ONE:  val = VAL_ONE;
      COIN_FIVE: val = VAL_FIVE;
      COIN_TEN:  val = VAL_TEN;
      default:   val = 4'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vending_fsm_multi_change_picker.sv
// Greedy change selector: picks the largest coin not exceeding the remaining credit.
// Zero credit yields no coin.
module vending_fsm_multi_change_picker
  import vending_fsm_multi_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output coin_code_t          coin_code,
  output logic [CREDIT_W-1:0] coin_val
);

  always_comb begin
    coin_code = COIN_NONE;
    if (credit >= CREDIT_W'(VAL_TEN)) begin
      coin_code = COIN_TEN;
    end else if (credit >= CREDIT_W'(VAL_FIVE)) begin
      coin_code = COIN_FIVE;
    end else if (credit >= CREDIT_W'(VAL_ONE)) begin
      coin_code = COIN_ONE;
    end
    coin_val = CREDIT_W'(coin_value(coin_code));
  end

endmodule

// File: rtl/vending_fsm_multi.sv
// Multi-slot vending controller: coin collection with a credit ceiling, per-slot
// affordability, vend strobe, cancel/refund and one-coin-per-cycle greedy change.
module vending_fsm_multi
  import vending_fsm_multi_pkg::*;
#(
  parameter int                            CREDIT_W   = 8,
  parameter int                            N_DRINKS   = 4,
  parameter int                            SEL_W      = 2,
  parameter logic [N_DRINKS*CREDIT_W-1:0]  PRICES     = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int                            MAX_CREDIT = 99
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                drink_req,
  input  logic [SEL_W-1:0]    drink_sel,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] total_coin,
  output logic [N_DRINKS-1:0] avail,
  output logic                drink_valid,
  output logic [SEL_W-1:0]    drink_id,
  output logic                deny,
  output logic                coin_reject,
  output logic [1:0]          change,
  output logic                busy
);

  localparam int SLOTS = 2 ** SEL_W;

  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [N_DRINKS-1:0] avail_q, avail_d;
  logic                drink_valid_q, drink_valid_d;
  logic [SEL_W-1:0]    drink_id_q, drink_id_d;
  logic                deny_q, deny_d;
  logic                coin_reject_q, coin_reject_d;
  coin_code_t          change_q, change_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] price_arr [SLOTS];
  logic [SLOTS-1:0]    affordable;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_present;
  logic                coin_fits;
  coin_code_t          pick_code;
  logic [CREDIT_W-1:0] pick_val;

  // Slots beyond N_DRINKS are never affordable, so out-of-range selections deny.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < N_DRINKS) begin : g_real
      assign price_arr[i]  = PRICES[i*CREDIT_W +: CREDIT_W];
      assign affordable[i] = (credit_q >= price_arr[i]);
      assign avail_d[i]    = (state_d == ST_COLLECT) && (credit_d >= price_arr[i]);
    end else begin : g_unused
      assign price_arr[i]  = '0;
      assign affordable[i] = 1'b0;
    end
  end

  assign coin_present = (coin != COIN_NONE);
  assign coin_val     = CREDIT_W'(coin_value(coin));
  assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_fits    = (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  vending_fsm_multi_change_picker #(
    .CREDIT_W (CREDIT_W)
  ) u_picker (
    .credit    (credit_q),
    .coin_code (pick_code),
    .coin_val  (pick_val)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    drink_valid_d = 1'b0;
    drink_id_d    = '0;
    deny_d        = 1'b0;
    coin_reject_d = 1'b0;
    change_d      = COIN_NONE;
    case (state_q)
      ST_IDLE: begin
        deny_d = drink_req;
        if (coin_present) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (cancel) begin
          state_d       = ST_CHANGE;
          coin_reject_d = coin_present;
        end else if (drink_req && affordable[drink_sel]) begin
          credit_d      = credit_q - price_arr[drink_sel];
          state_d       = ST_VEND;
          drink_valid_d = 1'b1;
          drink_id_d    = drink_sel;
          coin_reject_d = coin_present;
        end else begin
          deny_d = drink_req;
          if (coin_present) begin
            if (coin_fits) begin
              credit_d = coin_sum[CREDIT_W-1:0];
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_present;
        state_d       = (credit_q == '0) ? ST_IDLE : ST_CHANGE;
      end
      ST_CHANGE: begin
        coin_reject_d = coin_present;
        change_d      = pick_code;
        credit_d      = credit_q - pick_val;
        if (credit_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      avail_q       <= '0;
      drink_valid_q <= 1'b0;
      drink_id_q    <= '0;
      deny_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      change_q      <= COIN_NONE;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      avail_q       <= avail_d;
      drink_valid_q <= drink_valid_d;
      drink_id_q    <= drink_id_d;
      deny_q        <= deny_d;
      coin_reject_q <= coin_reject_d;
      change_q      <= change_d;
      busy_q        <= busy_d;
    end
  end

  assign total_coin  = credit_q;
  assign avail       = avail_q;
  assign drink_valid = drink_valid_q;
  assign drink_id    = drink_id_q;
  assign deny        = deny_q;
  assign coin_reject = coin_reject_q;
  assign change      = change_q;
  assign busy        = busy_q;

endmodule
